// File: rtl/timer_ctrl.sv
// Launch/pause/abort controller for an external up-counting timer.
// Counts expiries and optionally auto-reloads with the period latched at launch.
module timer_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_abort,
  input  logic             i_periodic,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_t_out,
  output logic             o_t_en,
  output logic             o_t_clr,
  output logic             o_busy,
  output logic             o_paused,
  output logic             o_done,
  output logic [CNT_W-1:0] o_expire_cnt,
  output logic             o_err
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_PAUSE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_period_q;
  logic             r_periodic_q;
  logic             r_t_clr;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_expire_cnt;

  logic w_at_term, w_expire, w_launch, w_refuse, w_t_en;

  assign w_at_term = (i_t_out == r_period_q);

  // Priority in RUN: abort > expiry > stop; enable drops in any cycle that leaves RUN
  // so the timer never runs past period_q or moves while pausing/aborting.
  always_comb begin
    w_state_nxt = r_state;
    w_t_en      = 1'b0;
    w_expire    = 1'b0;
    w_launch    = 1'b0;
    w_refuse    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_period != '0) begin
            w_launch    = 1'b1;
            w_state_nxt = S_CLEAR;
          end else begin
            w_refuse = 1'b1;
          end
        end
      end
      S_CLEAR: w_state_nxt = i_abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_at_term) begin
          w_expire    = 1'b1;
          w_state_nxt = r_periodic_q ? S_CLEAR : S_IDLE;
        end else if (i_stop) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_t_en = 1'b1;
        end
      end
      S_PAUSE: begin
        if (i_abort)      w_state_nxt = S_IDLE;
        else if (i_start) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // t_clr is a dedicated flop tracking entry into CLEAR, not a state decode.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_period_q   <= '0;
      r_periodic_q <= 1'b0;
      r_t_clr      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_expire_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t_clr <= (w_state_nxt == S_CLEAR);
      r_done  <= w_expire;
      r_err   <= w_refuse;
      if (w_expire) r_expire_cnt <= r_expire_cnt + 1'b1;
      if (w_launch) begin
        r_period_q   <= i_period;
        r_periodic_q <= i_periodic;
      end
    end
  end

  assign o_t_en       = w_t_en;
  assign o_t_clr      = r_t_clr;
  assign o_busy       = (r_state != S_IDLE);
  assign o_paused     = (r_state == S_PAUSE);
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_expire_cnt = r_expire_cnt;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: vector table for one-shot/error flow,
// hand sequences for periodic, pause, priority, wrap and reset corners.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, abort, per;
  logic [15:0] period;
  logic [15:0] tmr = 16'd7;
  logic        t_en, t_clr, busy, paused, done, err;
  logic [7:0]  cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_abort(abort),
    .i_periodic(per), .i_period(period), .i_t_out(tmr),
    .o_t_en(t_en), .o_t_clr(t_clr), .o_busy(busy), .o_paused(paused),
    .o_done(done), .o_expire_cnt(cnt), .o_err(err)
  );

  // The controlled timer itself.
  always @(posedge clk) begin
    if (t_clr)     tmr <= 16'd0;
    else if (t_en) tmr <= tmr + 16'd1;
  end

  always @(negedge clk) begin
    #2;
    if (t_clr === 1'b1 || t_en === 1'b1) begin
      n_cmp++;
      if (t_clr === 1'b1 && t_en === 1'b1) begin
        n_bad++;
        $display("FAIL clr_en_overlap: t_clr=%b t_en=%b want not both", t_clr, t_en);
      end
    end
  end

  typedef struct {
    logic rst, start, stop, abort, per;
    logic [15:0] period;
    logic en, clr, busy, pau, done, err;
    logic [7:0]  cnt;
    logic [15:0] tout;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; per = 1'b0; period = 16'd0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic launch(input logic [15:0] p, input logic pr);
    period = p; per = pr; start = 1'b1;
    cyc();
    start = 1'b0; period = 16'd0; per = 1'b0;
  endtask

  task automatic next_done(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (done !== 1'b1 && n < 50);
  endtask

  int n;

  initial begin
    //          rst st sp ab pr period | en clr bsy pau dn er cnt tout
    tbl[0]  = '{0, 1, 0, 0, 0, 16'd5,   0, 0, 0, 0, 0, 0, 8'd0, 16'd7};
    tbl[1]  = '{0, 0, 0, 0, 1, 16'd9,   0, 1, 1, 0, 0, 0, 8'd0, 16'd7};
    tbl[2]  = '{0, 0, 0, 0, 1, 16'd9,   1, 0, 1, 0, 0, 0, 8'd0, 16'd0};
    tbl[3]  = '{0, 0, 0, 0, 0, 16'd0,   1, 0, 1, 0, 0, 0, 8'd0, 16'd1};
    tbl[4]  = '{0, 0, 0, 0, 0, 16'd0,   1, 0, 1, 0, 0, 0, 8'd0, 16'd2};
    tbl[5]  = '{0, 0, 0, 0, 0, 16'd0,   1, 0, 1, 0, 0, 0, 8'd0, 16'd3};
    tbl[6]  = '{0, 0, 0, 0, 0, 16'd0,   1, 0, 1, 0, 0, 0, 8'd0, 16'd4};
    tbl[7]  = '{0, 0, 0, 0, 0, 16'd0,   0, 0, 1, 0, 0, 0, 8'd0, 16'd5};
    tbl[8]  = '{0, 0, 0, 0, 0, 16'd0,   0, 0, 0, 0, 1, 0, 8'd1, 16'd5};
    tbl[9]  = '{0, 1, 0, 0, 0, 16'd0,   0, 0, 0, 0, 0, 0, 8'd1, 16'd5};
    tbl[10] = '{0, 0, 0, 0, 0, 16'd0,   0, 0, 0, 0, 0, 1, 8'd1, 16'd5};
    tbl[11] = '{0, 0, 1, 0, 0, 16'd0,   0, 0, 0, 0, 0, 0, 8'd1, 16'd5};

    rst = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; per = 1'b0; period = 16'd0;
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst t_en", t_en, 0);   chk("rst t_clr", t_clr, 0); chk("rst busy", busy, 0);
    chk("rst paused", paused, 0); chk("rst done", done, 0); chk("rst err", err, 0);
    chk("rst cnt", cnt, 0);     chk("rst tmr_kept", tmr, 7);
    @(negedge clk);

    // One-shot period=5, mid-run input changes ignored, then period=0 refusal.
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
      abort = tbl[i].abort; per = tbl[i].per; period = tbl[i].period;
      #1;
      chk($sformatf("row%0d t_en", i), t_en, tbl[i].en);
      chk($sformatf("row%0d t_clr", i), t_clr, tbl[i].clr);
      chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("row%0d paused", i), paused, tbl[i].pau);
      chk($sformatf("row%0d done", i), done, tbl[i].done);
      chk($sformatf("row%0d err", i), err, tbl[i].err);
      chk($sformatf("row%0d cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("row%0d t_out", i), tmr, tbl[i].tout);
      cyc();
    end

    // Periodic period=3: done every 5 cycles, then abort freezes the timer.
    do_reset();
    launch(16'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      next_done(n);
      chk($sformatf("per spacing%0d", k), n, 5);
    end
    chk("per cnt4", cnt, 4);
    cyc();
    cyc();
    chk("per tmr1", tmr, 1);
    abort = 1'b1;
    #1;
    chk("abort t_en", t_en, 0);
    cyc();
    abort = 1'b0;
    #1;
    chk("abort busy", busy, 0); chk("abort done", done, 0); chk("abort tmr", tmr, 1);
    cyc();
    chk("abort tmr_hold", tmr, 1);

    // Pause at 4 for 7 cycles, resume with start+stop together.
    do_reset();
    launch(16'd10, 1'b0);
    cyc();
    repeat (4) cyc();
    chk("pause pre tmr", tmr, 4);
    stop = 1'b1;
    #1;
    chk("pause stop t_en", t_en, 0);
    cyc();
    for (int k = 0; k < 7; k++) begin
      stop = k[0];
      #1;
      chk($sformatf("pause hold%0d paused", k), paused, 1);
      chk($sformatf("pause hold%0d tmr", k), tmr, 4);
      cyc();
    end
    start = 1'b1; stop = 1'b1;
    #1;
    chk("resume t_en_in_pause", t_en, 0);
    cyc();
    start = 1'b0; stop = 1'b0;
    #1;
    chk("resume paused", paused, 0); chk("resume t_en", t_en, 1); chk("resume tmr", tmr, 4);
    next_done(n);
    chk("resume done_lat", n, 7);
    chk("resume tmr_end", tmr, 10); chk("resume cnt", cnt, 1); chk("resume busy", busy, 0);

    // Stop during expiry: expiry wins.
    do_reset();
    launch(16'd2, 1'b0);
    repeat (3) cyc();
    chk("stopexp tmr", tmr, 2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    #1;
    chk("stopexp done", done, 1); chk("stopexp paused", paused, 0);
    chk("stopexp busy", busy, 0); chk("stopexp cnt", cnt, 1);

    // Abort during expiry: abort wins, no done, count unchanged.
    launch(16'd2, 1'b1);
    repeat (3) cyc();
    abort = 1'b1; stop = 1'b1;
    #1;
    chk("abortexp t_en", t_en, 0);
    cyc();
    abort = 1'b0; stop = 1'b0;
    #1;
    chk("abortexp done", done, 0); chk("abortexp busy", busy, 0);
    chk("abortexp cnt", cnt, 1);   chk("abortexp tmr", tmr, 2);

    // 256 expiries with period=1 wrap the counter; then reset mid-RUN.
    do_reset();
    launch(16'd1, 1'b1);
    for (int k = 0; k < 256; k++) begin
      next_done(n);
      chk($sformatf("wrap spacing%0d", k), n, 3);
      if (k == 254) chk("wrap cnt255", cnt, 255);
    end
    chk("wrap cnt0", cnt, 0);
    cyc();
    chk("midrun busy", busy, 1); chk("midrun t_en", t_en, 1);
    rst = 1'b1; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst2 t_en", t_en, 0);   chk("rst2 t_clr", t_clr, 0); chk("rst2 busy", busy, 0);
    chk("rst2 paused", paused, 0); chk("rst2 done", done, 0); chk("rst2 err", err, 0);
    chk("rst2 cnt", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameters: WIDTH, 16, timer/period width; CNT_W, 8, expiry-counter width.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clock only.
REQ-004 start  in  1  level-sampled command: launch from IDLE, resume from PAUSE.
REQ-005 stop  in  1  pause command, honoured in RUN only.
REQ-006 abort  in  1  return to IDLE from any non-IDLE state.
REQ-007 periodic  in  1  latched with period at launch; 1 = auto-reload, 0 = one-shot.
REQ-008 period  in  WIDTH  terminal count, latched at launch into period_q.
REQ-009 t_out  in  WIDTH  current count of the controlled 16-bit timer.
REQ-010 t_en  out  1  count enable to the timer; timer increments on each edge where t_en=1.
REQ-011 t_clr  out  1  clear to the timer, driven directly from a flop (glitch-free).
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 paused  out  1  high in PAUSE.
REQ-014 done  out  1  one-cycle expiry pulse, registered.
REQ-015 expire_cnt  out  CNT_W  number of expiries since reset.
REQ-016 err  out  1  one-cycle pulse, registered: launch refused because period=0.

Function
REQ-017 States: IDLE, CLEAR, RUN, PAUSE; state held in a registered FSM.
REQ-018 IDLE: t_en=0, t_clr=0; start=1 and period!=0 -> latch period_q and periodic_q, go CLEAR.
REQ-019 IDLE with start=1 and period=0 -> stay IDLE, err=1 next cycle; nothing latched.
REQ-020 CLEAR: lasts exactly one cycle, t_clr=1, t_en=0; then RUN.
REQ-021 RUN: t_en = (t_out != period_q), decoded combinationally so the timer never passes period_q.
REQ-022 RUN with t_out == period_q (expiry cycle): done=1 in the following cycle; expire_cnt += 1, wrapping 2^CNT_W-1 -> 0.
REQ-023 Expiry with periodic_q=1 -> CLEAR (reload with the same period_q); periodic_q=0 -> IDLE.
REQ-024 Periodic spacing: consecutive done pulses are exactly period_q+2 cycles apart (1 CLEAR, period_q counting, 1 expiry).
REQ-025 RUN with stop=1 and no expiry in the same cycle -> PAUSE; the timer holds its value; expiry takes priority over stop.
REQ-026 PAUSE: t_en=0; start=1 -> RUN without clearing; stop is ignored.
REQ-027 abort=1 in CLEAR, RUN or PAUSE -> IDLE next cycle; t_en=0 in the abort cycle; no done; the timer keeps its value for readback; abort takes priority over start, stop and expiry.
REQ-028 Simultaneous start and stop in RUN -> PAUSE; in PAUSE -> RUN (start wins).
REQ-029 period and periodic are ignored outside IDLE; changing them mid-run has no effect.
REQ-030 t_clr is never high in the same cycle as t_en.

Reset
REQ-031 reset=1 at a clock edge -> state IDLE, period_q=0, periodic_q=0, expire_cnt=0, done=0, err=0, t_clr=0, t_en=0, busy=0, paused=0; overrides all inputs, including mid-run.
REQ-032 reset does not itself clear the timer; the first launch after reset always passes through CLEAR.

Verification
REQ-033 One-shot: period=5, periodic=0, start pulse -> 1 cycle t_clr, t_en high for 5 cycles (t_out 0..4), t_out=5 with t_en=0, done pulse, expire_cnt=1, back to IDLE, busy=0.
REQ-034 Periodic: period=3, periodic=1 -> done pulses every 5 cycles; after 4 pulses expire_cnt=4; abort -> IDLE with t_out frozen at its current value.
REQ-035 Pause/resume: period=10, stop at t_out=4, hold for 7 cycles -> t_out stays 4, paused=1; start -> counting resumes, done 6 counting cycles plus 1 cycle later.
REQ-036 Error and priority: start with period=0 -> err pulse, state IDLE; stop asserted in the expiry cycle -> expiry wins, done pulses, no PAUSE.
REQ-037 Wrap and reset: 256 periodic expiries with period=1 -> expire_cnt wraps to 0; reset asserted mid-RUN -> all outputs at reset values the next cycle.
